// File: rtl/pulpino_qsys_test_top.sv
// DE10-Nano bring-up harness standing in for PULPino/Qsys: reset sync, SETUP sweep, periodic timer IRQ on LEDs.
// Build option: define IRQ_AUTO_ACK_EN to auto-clear irq_pending 16 cycles after the most recent tick.
module pulpino_qsys_test_top #(
  parameter logic [31:0] BOOT_ADDR    = 32'h0000_8000,
  parameter int          SETUP_CYCLES = 256,
  parameter int          TICK_UNIT    = 64
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {ST_RESET, ST_SETUP, ST_RUN} state_t;

  // Fetch address on the last SETUP cycle; the sweep itself times the SETUP phase.
  localparam logic [31:0] SETUP_LAST = BOOT_ADDR + 32'(4 * (SETUP_CYCLES - 1));

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic [1:0]  r_ack_sync;
  logic [1:0]  r_pause_sync;
  logic        r_ack_prev;
  logic        w_ack;
  logic        w_pause;
  logic        w_unused_key3;

  state_t      r_state;
  logic [31:0] r_fetch_addr;
  logic [15:0] r_timer;
  logic [15:0] w_load;
  logic        w_tick;
  logic        r_run;
  logic        r_irq_pending;
  logic [7:0]  r_irq_count;

  assign w_unused_key3 = KEY[3];

  always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack_sync   <= 2'b00;
      r_pause_sync <= 2'b00;
      r_ack_prev   <= 1'b0;
    end else begin
      r_ack_sync   <= {r_ack_sync[0], KEY[1]};
      r_pause_sync <= {r_pause_sync[0], KEY[2]};
      r_ack_prev   <= r_ack_sync[1];
    end
  end

  // Buttons are active low: a press is a falling edge of the synchronized level.
  assign w_ack   = r_ack_prev & ~r_ack_sync[1];
  assign w_pause = ~r_pause_sync[1];

  // 16-bit modular arithmetic gives 65535 for SW=1023.
  assign w_load = (16'(SW) + 16'd1) * 16'(TICK_UNIT) - 16'd1;
  assign w_tick = (r_state == ST_RUN) && (r_timer == 16'd0) && !w_pause;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_RESET;
      r_fetch_addr <= BOOT_ADDR;
      r_timer      <= 16'd0;
      r_run        <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          r_fetch_addr <= r_fetch_addr + 32'd4;
          if (r_fetch_addr == SETUP_LAST) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
            r_timer <= w_load;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            r_timer <= w_load;
          end else if (!w_pause) begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state <= ST_RESET;
        end
      endcase
    end
  end

`ifdef IRQ_AUTO_ACK_EN
  logic [3:0] r_auto_cnt;

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_auto_cnt <= 4'd0;
    end else if (w_tick) begin
      r_auto_cnt <= 4'd15;
    end else if (r_irq_pending && (r_auto_cnt != 4'd0)) begin
      r_auto_cnt <= r_auto_cnt - 4'd1;
    end
  end
`endif

  // A tick outranks a simultaneous acknowledge, so pending survives that collision.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_irq_pending <= 1'b0;
      r_irq_count   <= 8'd0;
    end else if (w_tick) begin
      r_irq_pending <= 1'b1;
      r_irq_count   <= r_irq_count + 8'd1;
    end else if (w_ack) begin
      r_irq_pending <= 1'b0;
    end
`ifdef IRQ_AUTO_ACK_EN
    else if (r_irq_pending && (r_auto_cnt == 4'd0)) begin
      r_irq_pending <= 1'b0;
    end
`endif
  end

  assign LEDR = {r_run, r_irq_pending, r_irq_count};

endmodule

// File: tb/tb_pulpino_qsys_test_top.sv
// Randomized bench for pulpino_qsys_test_top: an event-level model predicts LEDR every cycle,
// plus hand-computed timing checks for reset, ticks, ack, pause, wrap and IRQ_AUTO_ACK_EN.
module tb_pulpino_qsys_test_top;

  localparam int SETUP_CYCLES = 256;
  localparam int TICK_UNIT    = 64;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int total = 0;
  int bad   = 0;
  int ed    = 0;
  bit m_checking = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  pulpino_qsys_test_top dut (
    .CLOCK_50(CLOCK_50),
    .KEY     (KEY),
    .SW      (SW),
    .LEDR    (LEDR)
  );

  // Model: count edges since reset release, count unpaused RUN cycles toward the sampled period.
  int       m_rst_edges = 0;
  int       m_k         = 0;
  int       m_period    = 0;
  int       m_elapsed   = 0;
  int       m_age       = 0;
  int       m_count     = 0;
  bit       m_run       = 1'b0;
  bit       m_pending   = 1'b0;
  bit [2:0] m_k1        = 3'b000;
  bit [2:0] m_k2        = 3'b000;

  always @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      m_rst_edges = 0; m_k = 0; m_period = 0; m_elapsed = 0; m_age = 0;
      m_count = 0; m_run = 1'b0; m_pending = 1'b0; m_k1 = 3'b000; m_k2 = 3'b000;
    end else if (m_rst_edges < 2) begin
      m_rst_edges++;
    end else begin
      bit ack, pause, tick;
      ack   = m_k1[2] & ~m_k1[1];
      pause = ~m_k2[1];
      tick  = 1'b0;
      m_k++;
      if (m_k == SETUP_CYCLES + 1) begin
        m_run     = 1'b1;
        m_period  = (int'(SW) + 1) * TICK_UNIT;
        m_elapsed = 0;
      end else if (m_run && !pause) begin
        m_elapsed++;
        if (m_elapsed == m_period) begin
          tick      = 1'b1;
          m_elapsed = 0;
          m_period  = (int'(SW) + 1) * TICK_UNIT;
        end
      end
      if (tick) begin
        m_pending = 1'b1;
        m_count   = (m_count + 1) % 256;
        m_age     = 0;
      end else if (ack) begin
        m_pending = 1'b0;
      end else if (m_pending) begin
        m_age++;
`ifdef IRQ_AUTO_ACK_EN
        if (m_age >= 16) m_pending = 1'b0;
`endif
      end
      m_k1 = {m_k1[1:0], KEY[1]};
      m_k2 = {m_k2[1:0], KEY[2]};
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One cycle: compare against the model at the falling edge, return just after the next rising edge.
  task automatic step();
    @(negedge CLOCK_50);
    if (m_checking) check("ledr_model", int'(LEDR), int'({m_run, m_pending, 8'(m_count)}));
    @(posedge CLOCK_50);
    #1;
    ed++;
  endtask

  task automatic run_to(input int target);
    while (ed < target) step();
  endtask

  task automatic release_and_find_run(input string name);
    int run_edge;
    run_edge = 0;
    KEY[0] = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (LEDR[9]) begin
        run_edge = i;
        break;
      end
    end
    check(name, run_edge, SETUP_CYCLES + 3);
    ed = 0;
  endtask

  initial begin
    KEY = 4'hF;
    SW  = 10'd0;
    #5 KEY[0] = 1'b0;
    m_checking = 1'b1;

    repeat (5) begin
      step();
      check("reset_ledr", int'(LEDR), 0);
    end
    release_and_find_run("run_edge");

    // SW=0: ticks every 64 cycles after RUN entry
    run_to(64);  check("tick1_count", int'(LEDR[7:0]), 1); check("tick1_pending", int'(LEDR[8]), 1);
    run_to(128); check("tick2_count", int'(LEDR[7:0]), 2);
    run_to(192); check("tick3_count", int'(LEDR[7:0]), 3);

    // ack latency: press right after the tick at 192
    KEY[1] = 1'b0;
    run_to(194); check("ack_lat2", int'(LEDR[8]), 1);
    run_to(195); check("ack_lat3", int'(LEDR[8]), 0);
    KEY[1] = 1'b1;

    // ack landing on the tick edge at 256
    run_to(253);
    KEY[1] = 1'b0;
    run_to(256);
    check("ack_vs_tick_count", int'(LEDR[7:0]), 4);
    check("ack_vs_tick_pending", int'(LEDR[8]), 1);
    KEY[1] = 1'b1;
    run_to(271); check("pending_t15", int'(LEDR[8]), 1);
    run_to(272);
`ifdef IRQ_AUTO_ACK_EN
    check("auto_ack_t16", int'(LEDR[8]), 0);
`else
    check("hold_t16", int'(LEDR[8]), 1);
`endif

    // period select: SW=3 takes effect at the tick at 320, mid-period change waits for 576
    SW = 10'd3;
    run_to(320); check("sw3_load_count", int'(LEDR[7:0]), 5);
    run_to(420); SW = 10'd0;
    run_to(575); check("sw3_before", int'(LEDR[7:0]), 5);
    run_to(576); check("sw3_tick", int'(LEDR[7:0]), 6);
    run_to(640); check("sw0_again", int'(LEDR[7:0]), 7);

    // pause for 1000 cycles starting with timer at 53
    run_to(650);
    KEY[2] = 1'b0;
    run_to(1650); check("pause_frozen", int'(LEDR[7:0]), 7);
    KEY[2] = 1'b1;
    run_to(1703); check("pause_resume_pre", int'(LEDR[7:0]), 7);
    run_to(1704); check("pause_resume_tick", int'(LEDR[7:0]), 8);

    // 256 ticks wrap the counter
    run_to(1704 + 248 * 64); check("wrap_zero", int'(LEDR[7:0]), 0);
    run_to(1704 + 256 * 64); check("wrap_full", int'(LEDR[7:0]), 8);

    // randomized phase, model-checked every cycle
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) SW = 10'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) KEY[1] = ~KEY[1];
      if (KEY[2] ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 19) == 0)) KEY[2] = ~KEY[2];
      step();
    end

    // reset mid-RUN clears LEDR without a clock edge, then SETUP replays
    KEY[0] = 1'b0;
    #1 check("reset_async", int'(LEDR), 0);
    KEY[1] = 1'b1;
    KEY[2] = 1'b1;
    SW     = 10'd0;
    repeat (3) step();
    release_and_find_run("replay_run_edge");
    run_to(64); check("replay_tick1", int'(LEDR[7:0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
